// File: rtl/timer_counter_if.sv
// Software-facing register bus of the 64-bit timer: control inputs, split-half
// write strobes, and the counter/compare/interrupt status read back.
interface timer_counter_if #(
  parameter int CNT_W = 64
);
  logic             timer_en;
  logic             div_en;
  logic [3:0]       div_val;
  logic [31:0]      wdata;
  logic             cnt_wr_lo;
  logic             cnt_wr_hi;
  logic             cmp_wr_lo;
  logic             cmp_wr_hi;
  logic             int_st_clear;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cmp;
  logic             int_st_set;
  logic             int_st;

  modport master (
    output timer_en, div_en, div_val, wdata,
    output cnt_wr_lo, cnt_wr_hi, cmp_wr_lo, cmp_wr_hi, int_st_clear,
    input  cnt, cmp, int_st_set, int_st
  );

  modport slave (
    input  timer_en, div_en, div_val, wdata,
    input  cnt_wr_lo, cnt_wr_hi, cmp_wr_lo, cmp_wr_hi, int_st_clear,
    output cnt, cmp, int_st_set, int_st
  );
endinterface

// File: rtl/timer_counter.sv
// Free-running timer with power-of-two prescaler, 64-bit compare and a
// rising-edge match interrupt (one-cycle pulse plus sticky status).
module timer_counter #(
  parameter int CNT_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  timer_counter_if.slave  bus
);
  localparam int HI_W = CNT_W - 32;

  logic [7:0]       div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic             match_q, match_d;
  logic             int_st_set_q, int_st_set_d;
  logic             int_st_q, int_st_d;

  logic [3:0]       div_exp;
  logic [7:0]       div_lim;
  logic             tick;
  logic             match;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    tick      = 1'b0;
    div_cnt_d = 8'd0;
    div_exp   = (bus.div_val > 4'd8) ? 4'd8 : bus.div_val;
    div_lim   = 8'((9'd1 << div_exp) - 9'd1);

    // Using >= rather than == means a limit lowered below the running count
    // still ticks on the next cycle instead of waiting for an 8-bit wrap.
    if (bus.timer_en) begin
      if (!bus.div_en || (div_cnt_q >= div_lim)) tick = 1'b1;
      else                                       div_cnt_d = div_cnt_q + 8'd1;
    end

    // Any software write to cnt suppresses the increment for both halves.
    cnt_d = cnt_q;
    if (bus.cnt_wr_lo || bus.cnt_wr_hi) begin
      if (bus.cnt_wr_lo) cnt_d[31:0]      = bus.wdata;
      if (bus.cnt_wr_hi) cnt_d[CNT_W-1:32] = bus.wdata[HI_W-1:0];
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    cmp_d = cmp_q;
    if (bus.cmp_wr_lo) cmp_d[31:0]      = bus.wdata;
    if (bus.cmp_wr_hi) cmp_d[CNT_W-1:32] = bus.wdata[HI_W-1:0];

    match        = (cnt_q == cmp_q);
    match_d      = match;
    int_st_set_d = match && !match_q;
    int_st_d     = int_st_set_d || (int_st_q && !bus.int_st_clear);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= 8'd0;
      cnt_q        <= '0;
      cmp_q        <= '1;
      match_q      <= 1'b0;
      int_st_set_q <= 1'b0;
      int_st_q     <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      cnt_q        <= cnt_d;
      cmp_q        <= cmp_d;
      match_q      <= match_d;
      int_st_set_q <= int_st_set_d;
      int_st_q     <= int_st_d;
    end
  end

  assign bus.cnt        = cnt_q;
  assign bus.cmp        = cmp_q;
  assign bus.int_st_set = int_st_set_q;
  assign bus.int_st     = int_st_q;
endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a cycle-by-cycle vector table followed by
// long prescaler sequences, all expectations hand-computed.
module tb_timer_counter;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;

  timer_counter_if #(.CNT_W(64)) bus ();

  timer_counter #(.CNT_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic        den;
    logic [3:0]  dval;
    logic [31:0] wdata;
    logic        cwl, cwh, mwl, mwh, clr;
    logic [63:0] exp_cnt;
    logic [63:0] exp_cmp;
    logic        exp_set;
    logic        exp_st;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  function automatic void add(input string name, input logic r, input logic en, input logic den,
                              input logic [3:0] dval, input logic [31:0] wdata,
                              input logic cwl, input logic cwh, input logic mwl, input logic mwh,
                              input logic clr, input logic [63:0] ecnt, input logic [63:0] ecmp,
                              input logic eset, input logic est);
    vec_t v;
    v.name = name; v.rst = r; v.en = en; v.den = den; v.dval = dval; v.wdata = wdata;
    v.cwl = cwl; v.cwh = cwh; v.mwl = mwl; v.mwh = mwh; v.clr = clr;
    v.exp_cnt = ecnt; v.exp_cmp = ecmp; v.exp_set = eset; v.exp_st = est;
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    rst              = v.rst;
    bus.timer_en     = v.en;
    bus.div_en       = v.den;
    bus.div_val      = v.dval;
    bus.wdata        = v.wdata;
    bus.cnt_wr_lo    = v.cwl;
    bus.cnt_wr_hi    = v.cwh;
    bus.cmp_wr_lo    = v.mwl;
    bus.cmp_wr_hi    = v.mwh;
    bus.int_st_clear = v.clr;
  endtask

  task automatic check_outputs(input string tag, input logic [63:0] ecnt, input logic [63:0] ecmp,
                               input logic eset, input logic est);
    check($sformatf("%s.cnt", tag), bus.cnt, ecnt);
    check($sformatf("%s.cmp", tag), bus.cmp, ecmp);
    check($sformatf("%s.int_st_set", tag), 64'(bus.int_st_set), 64'(eset));
    check($sformatf("%s.int_st", tag), 64'(bus.int_st), 64'(est));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   name            rst en den dv wdata          cwl cwh mwl mwh clr  cnt                    cmp                    set st
    add("reset",          1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h0,                 ONES,                  0, 0);
    add("rst_ignores_wr", 1, 1, 0, 0, 32'h7,          1, 0, 1, 0, 0,   64'h0,                 ONES,                  0, 0);
    add("cmp_lo",         0, 0, 0, 0, 32'h5,          0, 0, 1, 0, 0,   64'h0,                 64'hFFFF_FFFF_0000_0005, 0, 0);
    add("cmp_hi",         0, 0, 0, 0, 32'h0,          0, 0, 0, 1, 0,   64'h0,                 64'h5,                 0, 0);
    add("count1",         0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h1,                 64'h5,                 0, 0);
    add("count2",         0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h2,                 64'h5,                 0, 0);
    add("count3",         0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h3,                 64'h5,                 0, 0);
    add("count4",         0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h4,                 64'h5,                 0, 0);
    add("count5",         0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h5,                 64'h5,                 0, 0);
    add("match_pulse",    0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h5,                 64'h5,                 1, 1);
    add("const_match",    0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h5,                 64'h5,                 0, 1);
    add("leave_match",    0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h6,                 64'h5,                 0, 1);
    add("wr_to_match",    0, 0, 0, 0, 32'h5,          1, 0, 0, 0, 0,   64'h5,                 64'h5,                 0, 1);
    add("set_beats_clr",  0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 1,   64'h5,                 64'h5,                 1, 1);
    add("clr_alone",      0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 1,   64'h5,                 64'h5,                 0, 0);
    add("idle_hold",      0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h5,                 64'h5,                 0, 0);
    add("cnt_both_wr",    0, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0,   64'h0,                 64'h5,                 0, 0);
    add("cmp_both_wr",    0, 0, 0, 0, 32'hFFFF_FFFF,  0, 0, 1, 1, 0,   64'h0,                 ONES,                  0, 0);
    for (int k = 1; k <= 16; k++)
      add($sformatf("presc2_%0d", k), 0, 1, 1, 4'd2, 32'h0, 0, 0, 0, 0, 0, 64'(k / 4), ONES, 0, 0);
    add("wrap_cnt_lo",    0, 0, 0, 0, 32'hFFFF_FFFE,  1, 0, 0, 0, 0,   64'h0000_0000_FFFF_FFFE, ONES,               0, 0);
    add("wrap_cnt_hi",    0, 0, 0, 0, 32'hFFFF_FFFF,  0, 1, 0, 0, 0,   64'hFFFF_FFFF_FFFF_FFFE, ONES,               0, 0);
    add("wrap_cmp0",      0, 0, 0, 0, 32'h0,          0, 0, 1, 1, 0,   64'hFFFF_FFFF_FFFF_FFFE, 64'h0,              0, 0);
    add("wrap_tick1",     0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0,   ONES,                  64'h0,                 0, 0);
    add("wrap_tick2",     0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h0,                 64'h0,                 0, 0);
    add("wrap_pulse",     0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h0,                 64'h0,                 1, 1);
    add("wrap_one_pulse", 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h0,                 64'h0,                 0, 1);
    add("wrap_clr",       0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 1,   64'h0,                 64'h0,                 0, 0);
    add("cnt_hi_1",       0, 0, 0, 0, 32'h1,          0, 1, 0, 0, 0,   64'h1_0000_0000,       64'h0,                 0, 0);
    add("wr_beats_tick",  0, 1, 0, 0, 32'h10,         1, 0, 0, 0, 0,   64'h1_0000_0010,       64'h0,                 0, 0);
    add("cmp_100",        0, 0, 0, 0, 32'd100,        0, 0, 1, 0, 0,   64'h1_0000_0010,       64'd100,               0, 0);
    add("cnt_hi_0",       0, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0,   64'h10,                64'd100,               0, 0);
    add("cnt_100",        0, 0, 0, 0, 32'd100,        1, 0, 0, 0, 0,   64'd100,               64'd100,               0, 0);
    add("pulse_100",      0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'd100,               64'd100,               1, 1);
    add("rst_in_pulse",   1, 1, 0, 0, 32'h7,          1, 0, 0, 0, 0,   64'h0,                 ONES,                  0, 0);
    add("post_rst_quiet", 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0,   64'h0,                 ONES,                  0, 0);

    drive(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_outputs(vecs[i].name, vecs[i].exp_cnt, vecs[i].exp_cmp, vecs[i].exp_set, vecs[i].exp_st);
    end

    // div_val=9 clamps to 8: one tick per 256 cycles from a fresh reset.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; bus.timer_en = 1'b1; bus.div_en = 1'b1; bus.div_val = 4'd9;
    repeat (255) @(posedge clk);
    #1;
    check("div9_255cyc.cnt", bus.cnt, 64'd0);
    @(posedge clk);
    #1;
    check("div9_256cyc.cnt", bus.cnt, 64'd1);

    // Lowering div_val below the running div_cnt must tick on the next edge.
    bus.div_val = 4'd8;
    repeat (200) @(posedge clk);
    #1;
    check("div8_200cyc.cnt", bus.cnt, 64'd1);
    bus.div_val = 4'd2;
    @(posedge clk);
    #1;
    check("div_shrink_tick.cnt", bus.cnt, 64'd2);
    repeat (4) @(posedge clk);
    #1;
    check("div2_after_shrink.cnt", bus.cnt, 64'd3);
    check("div_no_pulse.int_st_set", 64'(bus.int_st_set), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter CNT_W: default 64. Counter and compare width; written as two 32-bit halves.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 timer_en  in  1  1 = counting enabled.
REQ-005 div_en  in  1  1 = prescaler active; 0 = count every cycle.
REQ-006 div_val  in  4  prescale exponent; tick period 2^div_val cycles; legal 0..8.
REQ-007 wdata  in  32  software write data.
REQ-008 cnt_wr_lo / cnt_wr_hi  in  1 each  write strobe, cnt[31:0] / cnt[63:32].
REQ-009 cmp_wr_lo / cmp_wr_hi  in  1 each  write strobe, cmp[31:0] / cmp[63:32].
REQ-010 int_st_clear  in  1  write-1-to-clear pulse for int_st.
REQ-011 cnt  out  64  current counter value.
REQ-012 cmp  out  64  current compare value.
REQ-013 int_st_set  out  1  single-cycle compare-match pulse, consumed by the interrupt block.
REQ-014 int_st  out  1  sticky interrupt status.

Function
REQ-015 Divider: internal 8-bit div_cnt held at 0 whenever timer_en=0 or div_en=0.
REQ-016 With timer_en=1, div_en=1: tick when div_cnt >= 2^div_val-1, then div_cnt <= 0; else div_cnt increments, no tick.
REQ-017 div_val > 8: treated as 8.
REQ-018 div_val changed mid-count: >= comparison guarantees a tick within 256 cycles; no lockup.
REQ-019 With timer_en=1, div_en=0: tick every cycle.
REQ-020 Counter: cnt <= cnt+1 on tick; wraps 0xFFFF_FFFF_FFFF_FFFF -> 0 without extra event.
REQ-021 cnt_wr_lo/cnt_wr_hi: write wdata into the selected half at the next edge, overriding any increment in that cycle.
REQ-022 During a cnt write cycle the unwritten half holds its value; both strobes together load both halves with wdata.
REQ-023 cmp_wr_lo/cmp_wr_hi: load wdata into the selected half of cmp; cmp is never modified otherwise.
REQ-024 Match: match = (cnt == cmp), evaluated every cycle regardless of timer_en; registered match_q <= match.
REQ-025 int_st_set: registered; high for exactly one cycle in cycle N+1 when match=1 in cycle N and match_q=0 in cycle N.
REQ-026 Constant match (timer stopped on match): a single int_st_set pulse only; re-arms only after match drops for at least one cycle.
REQ-027 Match created by a cnt or cmp write pulses int_st_set exactly as a match created by counting.
REQ-028 int_st: set on the same edge that raises int_st_set; cleared on the edge after int_st_clear=1; otherwise holds.
REQ-029 Simultaneous set condition and int_st_clear: set wins, int_st stays 1.
REQ-030 Latency: tick edge -> cnt updated; cnt==cmp -> int_st_set/int_st high one cycle later.

Reset
REQ-031 rst=1 at an edge: cnt=0, cmp=0xFFFF_FFFF_FFFF_FFFF, div_cnt=0, match_q=0, int_st_set=0, int_st=0; all writes and ticks that cycle ignored.
REQ-032 rst asserted mid-count or during an int_st_set pulse: same values next edge; no pulse emitted after release until a fresh match rising edge.

Verification
REQ-033 timer_en=1, div_en=0, cmp=5 from reset -> cnt=5 after 5 ticks; int_st_set high one cycle, int_st=1 thereafter.
REQ-034 div_en=1, div_val=2, timer_en=1 for 16 cycles -> cnt=4; div_val=9 -> increments every 256 cycles.
REQ-035 cnt=0xFFFF_FFFF_FFFF_FFFE, cmp=0, counting -> wraps to 0 after 2 ticks; one int_st_set pulse.
REQ-036 int_st=1, set condition and int_st_clear same cycle -> int_st stays 1; int_st_clear alone next -> int_st=0.
REQ-037 Same-cycle tick and cnt_wr_lo, wdata=0x10, cnt_hi=0x1 -> cnt=0x1_0000_0010, no increment.
REQ-038 rst pulsed at cnt=100, int_st=1 -> all outputs at reset values next edge; cmp=0xFFFF_FFFF_FFFF_FFFF.
